rvv_wb_collect: RTL
===================

// Module: rvv_wb_collect
// PURPOSE
//  Writeback collector downstream of the per-lane vector ALUs. It gathers the lane results
//  (data plus destination bit index) for one vector instruction into a VLEN-bit image of vd.
//  It merges those results over the old vd contents, then issues one full-width write with
//  byte enables to the vector register file using a valid/ready handshake.
//  Sits between the ALU lane array and the vreg file write port.
// PARAMETERS
//  VLEN        10'd128  vector register width in bits
//  LANE_WIDTH  3'b011   log2 of lane width in bits (LW = 1<<LANE_WIDTH: 8/16/32/64)
//  NLANES      4        lane result slots accepted per cycle (1..4, matches 2^nb_lanes max)
// PORTS
//  clk          in   1           clock, rising edge
//  resetn       in   1           reset, asynchronous, active-low
//  start        in   1           begin collecting a new instruction (accepted in IDLE only)
//  vd_addr      in   5           destination register number, latched on start
//  vl           in   8           element count, latched on start
//  vsew         in   3           element width code (SEW = 8<<vsew, 0..3), latched on start
//  old_vd       in   VLEN        current vd contents, latched on start (undisturbed base)
//  lane_valid   in   NLANES      per-lane result valid
//  lane_data    in   NLANES*64   per-lane result, low LW bits used
//  lane_index   in   NLANES*10   per-lane destination bit index (LW-aligned)
//  lane_ready   out  1           collector accepts lane results this cycle
//  wr_valid     out  1           register-file write request
//  wr_ready     in   1           register-file accepts write
//  wr_addr      out  5           write register number
//  wr_data      out  VLEN        assembled vd image
//  wr_be        out  VLEN/8      byte enables (bytes below vl*SEW/8)
//  done         out  1           one-cycle pulse: instruction retired
//  err          out  1           sticky: illegal lane beat seen; cleared on next accepted start
// BEHAVIOUR
//  - Reset (async): state IDLE; buffer, counters, wr_* , lane_ready, done, err all 0.
//  - Reset mid-operation aborts the instruction; no write is issued.
//  - FSM IDLE -> COLLECT -> WRITE -> IDLE.
//  - IDLE with start=1: latch inputs, buf<=old_vd, beat_cnt<=0, err<=0.
//    - vl==0: stay IDLE and pulse done next cycle; no write.
//    - otherwise: go to COLLECT.
//  - Expected beats: EXP = vl * max(1, SEW>>LANE_WIDTH), computed in 11 bits at start.
//  - Bits written per beat: W = min(SEW, LW), taken from lane_data[W-1:0].
//  - COLLECT: lane_ready=1. Each valid lane writes buf[lane_index +: W].
//    - beat_cnt += popcount(lane_valid & ~already_counted).
//    - Same index on two lanes in one cycle: the higher lane number wins; both beats counted.
//    - lane_index+W > VLEN, or lane_index not W-aligned: data dropped, beat counted, err<=1.
//    - When beat_cnt reaches EXP (including beats in the current cycle) -> WRITE next cycle.
//    - Beats in excess of EXP within that cycle are dropped and set err.
//  - WRITE: wr_valid=1, lane_ready=0; wr_data/wr_be/wr_addr held stable until wr_ready.
//    - Handshake (wr_valid&wr_ready) -> IDLE, done=1 the following cycle.
//    - lane_valid while lane_ready=0: ignored, err<=1. start outside IDLE: ignored.
//  - wr_be[b] = (b < vl*SEW/8), saturated at VLEN/8. Tail bytes keep old_vd in wr_data.
//  - Latency: last beat -> wr_valid is 1 cycle; handshake -> done is 1 cycle.
// CONFIGURATION
//  - RVV_WB_MASK_EN defined: adds inputs vm (1) and v0_mask (VLEN/8).
//    - Both are latched on start.
//    - If vm=0, element i with v0_mask[i]=0 has its bytes cleared in wr_be and keeps old_vd.
//    - Beats for masked elements are still counted.
//  - RVV_WB_MASK_EN undefined: no ports; every body element is enabled.
// STRUCTURE
//  - Shared package rvv_pkg:
//    - FSM state enum (IDLE/COLLECT/WRITE).
//    - VSEW code constants.
//    - function sew_bits(vsew).
//    - function beats_per_elem(vsew, LANE_WIDTH).
//  - One sub-module, rvv_wb_be_gen: combinational byte-enable generator
//    (vl, vsew[, vm, v0_mask]) -> wr_be.
//  - FSM, counter and buffer stay in the top.
// TESTING  (VLEN=128, LANE_WIDTH=3, NLANES=4)
//  - vsew=0, vl=16, old_vd=0.
//    - Stimulus: 4 cycles of 4 lanes, indices 0..120, data=byte number.
//    - Response: wr_valid 1 cycle after the last beat; wr_be=16'hFFFF; wr_data byte k = k.
//  - vsew=1, vl=5, old_vd all 8'hAA.
//    - Stimulus: 10 beats of 8'h55.
//    - Response: wr_be=16'h03FF; bytes 0-9 = 55; bytes 10-15 = AA.
//  - Hold wr_ready=0 for 3 cycles.
//    - Response: wr_* stable and lane_ready=0 throughout.
//    - After wr_ready: done pulses exactly once, 1 cycle after the handshake; FSM back in IDLE.
//  - vl=0 start.
//    - Response: done pulses 1 cycle later; wr_valid never asserted.
//  - Out-of-range beat: lane_index=128 in the middle of a vl=16 vsew=0 op.
//    - Response: err=1; write still issued after 16 beats.
//    - err clears on the next start.
//  - RVV_WB_MASK_EN: vsew=0, vl=16, vm=0, v0_mask=16'h00F0.
//    - Response: wr_be=16'h00F0; unmasked bytes keep old_vd.
//  - Async reset asserted mid-COLLECT.
//    - Response: outputs 0 immediately; no write issued.

Source files
------------

// File: rtl/rvv_pkg.sv
// Shared types and helpers for the RVV writeback collector.
// Holds the FSM state encoding, the VSEW codes and the SEW/beat arithmetic.
package rvv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2
   } wb_state_t;

   localparam logic [2:0] VSEW_E8  = 3'd0;
   localparam logic [2:0] VSEW_E16 = 3'd1;
   localparam logic [2:0] VSEW_E32 = 3'd2;
   localparam logic [2:0] VSEW_E64 = 3'd3;

   function automatic logic [6:0] sew_bits(input logic [2:0] vsew);
      logic [6:0] w_bits;
      case (vsew)
         VSEW_E8:  w_bits = 7'd8;
         VSEW_E16: w_bits = 7'd16;
         VSEW_E32: w_bits = 7'd32;
         VSEW_E64: w_bits = 7'd64;
         default:  w_bits = 7'd8;
      endcase
      return w_bits;
   endfunction

   // An element wider than a lane arrives as several lane-sized beats.
   function automatic logic [3:0] beats_per_elem(input logic [2:0] vsew, input logic [2:0] lane_width);
      logic [6:0] w_ratio;
      w_ratio = sew_bits(vsew) >> lane_width;
      return (w_ratio == 7'd0) ? 4'd1 : 4'(w_ratio);
   endfunction

endpackage

// File: rtl/rvv_wb_be_gen.sv
// Byte-enable generator: a byte is enabled when it lies below vl*SEW/8.
// With RVV_WB_MASK_EN defined, elements whose v0 mask bit is clear are also disabled when vm=0.
module rvv_wb_be_gen #(
   parameter int VLEN = 128
)(
   input  logic [7:0]        vl,
   input  logic [2:0]        vsew,
`ifdef RVV_WB_MASK_EN
   input  logic              vm,
   input  logic [VLEN/8-1:0] v0_mask,
`endif
   output logic [VLEN/8-1:0] be
);
   localparam int NB = VLEN / 8;

   logic [10:0] w_body_bytes;
   assign w_body_bytes = {3'b000, vl} << vsew;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_byte
         localparam logic [10:0] BYTE_NUM = 11'(gi);
         logic w_elem_en;
`ifdef RVV_WB_MASK_EN
         localparam int IW = $clog2(NB);
         logic [IW-1:0] w_elem_idx;
         assign w_elem_idx = IW'(gi) >> vsew;
         assign w_elem_en  = vm | v0_mask[w_elem_idx];
`else
         assign w_elem_en  = 1'b1;
`endif
         assign be[gi] = w_elem_en & (BYTE_NUM < w_body_bytes);
      end
   endgenerate

endmodule

// File: rtl/rvv_wb_collect.sv
// Vector writeback collector: merges per-lane ALU results over old vd and issues one
// byte-enabled register-file write. Optional masking is enabled by defining RVV_WB_MASK_EN.
module rvv_wb_collect
   import rvv_pkg::*;
#(
   parameter int VLEN       = 128,
   parameter int LANE_WIDTH = 3,
   parameter int NLANES     = 4
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [4:0]           vd_addr,
   input  logic [7:0]           vl,
   input  logic [2:0]           vsew,
   input  logic [VLEN-1:0]      old_vd,
`ifdef RVV_WB_MASK_EN
   input  logic                 vm,
   input  logic [VLEN/8-1:0]    v0_mask,
`endif
   input  logic [NLANES-1:0]    lane_valid,
   input  logic [NLANES*64-1:0] lane_data,
   input  logic [NLANES*10-1:0] lane_index,
   output logic                 lane_ready,
   output logic                 wr_valid,
   input  logic                 wr_ready,
   output logic [4:0]           wr_addr,
   output logic [VLEN-1:0]      wr_data,
   output logic [VLEN/8-1:0]    wr_be,
   output logic                 done,
   output logic                 err
);
   localparam int          LW        = 1 << LANE_WIDTH;
   localparam int          NB        = VLEN / 8;
   localparam logic [11:0] VLEN_BITS = 12'(VLEN);

   wb_state_t       r_state, w_state_next;
   logic [VLEN-1:0] r_buf, w_buf_next;
   logic [10:0]     r_beat_cnt, w_cnt_next, r_exp;
   logic [4:0]      r_vd_addr;
   logic [7:0]      r_vl;
   logic [2:0]      r_vsew;
   logic            r_done, w_done_next;
   logic            r_err, w_err_next;
   logic            w_latch;
`ifdef RVV_WB_MASK_EN
   logic            r_vm;
   logic [NB-1:0]   r_v0_mask;
`endif
   logic [NB-1:0]   w_be;
   logic [VLEN-1:0] w_be_bits;
   logic [6:0]      w_wbits;
   logic [63:0]     w_wmask;
   logic [10:0]     w_idx;
   logic [11:0]     w_end;
   logic [VLEN-1:0] w_field, w_wdata;

   assign w_wbits = (sew_bits(r_vsew) > 7'(LW)) ? 7'(LW) : sew_bits(r_vsew);
   // Wraps to all-ones when w_wbits is 64.
   assign w_wmask = (64'd1 << w_wbits) - 64'd1;

   rvv_wb_be_gen #(.VLEN(VLEN)) u_be_gen (
      .vl      (r_vl),
      .vsew    (r_vsew),
`ifdef RVV_WB_MASK_EN
      .vm      (r_vm),
      .v0_mask (r_v0_mask),
`endif
      .be      (w_be)
   );

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_be_bits
         assign w_be_bits[gi*8 +: 8] = {8{w_be[gi]}};
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_buf_next   = r_buf;
      w_cnt_next   = r_beat_cnt;
      w_err_next   = r_err;
      w_done_next  = 1'b0;
      w_latch      = 1'b0;
      w_idx        = '0;
      w_end        = '0;
      w_field      = '0;
      w_wdata      = '0;
      case (r_state)
         ST_IDLE: begin
            if (lane_valid != '0) w_err_next = 1'b1;
            if (start) begin
               w_latch    = 1'b1;
               w_err_next = 1'b0;
               w_cnt_next = '0;
               w_buf_next = old_vd;
               if (vl == 8'd0) w_done_next  = 1'b1;
               else            w_state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // Lanes are applied in ascending order so the higher lane wins a shared index.
            for (int i = 0; i < NLANES; i++) begin
               if (lane_valid[i]) begin
                  if (w_cnt_next >= r_exp) begin
                     w_err_next = 1'b1;
                  end else begin
                     w_cnt_next = w_cnt_next + 11'd1;
                     w_idx      = {1'b0, lane_index[i*10 +: 10]};
                     w_end      = {1'b0, w_idx} + {5'd0, w_wbits};
                     if (w_end > VLEN_BITS || (w_idx & {4'd0, w_wbits - 7'd1}) != 11'd0) begin
                        w_err_next = 1'b1;
                     end else begin
                        w_field    = (VLEN'(w_wmask) << w_idx) & w_be_bits;
                        w_wdata    = VLEN'(lane_data[i*64 +: 64]) << w_idx;
                        w_buf_next = (w_buf_next & ~w_field) | (w_wdata & w_field);
                     end
                  end
               end
            end
            if (w_cnt_next >= r_exp) w_state_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (lane_valid != '0) w_err_next = 1'b1;
            if (wr_ready) begin
               w_state_next = ST_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_buf      <= '0;
         r_beat_cnt <= '0;
         r_exp      <= '0;
         r_vd_addr  <= '0;
         r_vl       <= '0;
         r_vsew     <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef RVV_WB_MASK_EN
         r_vm       <= 1'b0;
         r_v0_mask  <= '0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_buf      <= w_buf_next;
         r_beat_cnt <= w_cnt_next;
         r_done     <= w_done_next;
         r_err      <= w_err_next;
         if (w_latch) begin
            r_vd_addr <= vd_addr;
            r_vl      <= vl;
            r_vsew    <= vsew;
            r_exp     <= 11'(vl) * 11'(beats_per_elem(vsew, 3'(LANE_WIDTH)));
`ifdef RVV_WB_MASK_EN
            r_vm      <= vm;
            r_v0_mask <= v0_mask;
`endif
         end
      end
   end

   assign lane_ready = (r_state == ST_COLLECT);
   assign wr_valid   = (r_state == ST_WRITE);
   assign wr_addr    = r_vd_addr;
   assign wr_data    = r_buf;
   assign wr_be      = w_be;
   assign done       = r_done;
   assign err        = r_err;

endmodule
